// File: rtl/toggle_burst_ctrl_pkg.sv
// rtl/toggle_burst_ctrl_pkg.sv - shared state encoding and parameter defaults for the toggle burst controller
package toggle_burst_ctrl_pkg;

    // Controller states; the encoding is kept stable so state can be probed in debug
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int   CNT_W_DEFAULT      = 16;
    localparam int   NUM_W_DEFAULT      = 8;
    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/toggle_burst_ctrl_toggle_reg.sv
// rtl/toggle_burst_ctrl_toggle_reg.sv - the sig flip-flop with sync reset, sync load and toggle enable
module toggle_reg #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic load_value,
    input  logic toggle_en,
    output logic sig
);

    // Reset beats load, load beats toggle, otherwise hold
    always_ff @(posedge clock) begin
        if (reset) begin
            sig <= RESET_LEVEL;
        end else if (load) begin
            sig <= load_value;
        end else if (toggle_en) begin
            sig <= ~sig;
        end
    end

endmodule

// File: rtl/toggle_burst_ctrl.sv
// rtl/toggle_burst_ctrl.sv - command-driven burst controller that toggles sig_out a requested number of times
module toggle_burst_ctrl
    import toggle_burst_ctrl_pkg::*;
#(
    parameter int   CNT_W      = CNT_W_DEFAULT,
    parameter int   NUM_W      = NUM_W_DEFAULT,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_half_period,
    input  logic [NUM_W-1:0] cmd_num_toggles,
    input  logic             abort,
    output logic             sig_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [NUM_W-1:0] toggles_left
);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  counter;
    logic [CNT_W-1:0]  reload;
    logic [CNT_W-1:0]  half_m1;
    logic              accept;
    logic              abort_run;
    logic              tick;

    // A half-period of 0 behaves like 1, so the reload value never underflows
    always_comb begin
        half_m1 = '0;
        if (cmd_half_period != '0) begin
            half_m1 = cmd_half_period - CNT_W'(1);
        end
    end

    assign accept    = cmd_valid & cmd_ready;
    assign abort_run = (state == ST_RUN) & abort;
    // Abort wins over a period expiry in the same cycle, so no toggle happens then
    assign tick      = (state == ST_RUN) & (counter == '0) & ~abort;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (cmd_num_toggles == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (tick && toggles_left == NUM_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready = (state == ST_IDLE) & ~abort;
        busy      = (state == ST_RUN);
        done      = (state == ST_DONE);
    end

    // Period counter, stored reload value and remaining-toggle count
    always_ff @(posedge clock) begin
        if (reset) begin
            counter      <= '0;
            reload       <= '0;
            toggles_left <= '0;
        end else if (accept) begin
            counter      <= half_m1;
            reload       <= half_m1;
            toggles_left <= cmd_num_toggles;
        end else if (abort_run) begin
            counter      <= '0;
            toggles_left <= '0;
        end else if (state == ST_RUN) begin
            if (counter != '0) begin
                counter <= counter - CNT_W'(1);
            end else begin
                counter <= reload;
                if (toggles_left != '0) begin
                    toggles_left <= toggles_left - NUM_W'(1);
                end
            end
        end
    end

    // One-cycle pulse in the cycle after an abort took effect
    always_ff @(posedge clock) begin
        if (reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_run;
        end
    end

    toggle_reg #(
        .RESET_LEVEL (IDLE_LEVEL)
    ) u_toggle_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (abort_run),
        .load_value (IDLE_LEVEL),
        .toggle_en  (tick),
        .sig        (sig_out)
    );

endmodule

// File: tb/tb_toggle_burst_ctrl.sv
// tb/tb_toggle_burst_ctrl.sv - directed self-checking bench for toggle_burst_ctrl
module tb_toggle_burst_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_half_period;
    logic [7:0]  cmd_num_toggles;
    logic        abort;
    logic        sig_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  toggles_left;

    int checks   = 0;
    int failures = 0;

    toggle_burst_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_half_period (cmd_half_period),
        .cmd_num_toggles (cmd_num_toggles),
        .abort           (abort),
        .sig_out         (sig_out),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .toggles_left    (toggles_left)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Accept one command and check every cycle until cmd_ready returns; burst starts at sig=0
    task automatic run_burst(input int h, input int n);
        int t;
        int total;
        t     = (h == 0) ? 1 : h;
        total = n * t;
        chk("ready_pre", 32'(cmd_ready), 32'd1);
        cmd_valid       = 1'b1;
        cmd_half_period = 16'(h);
        cmd_num_toggles = 8'(n);
        step();
        cmd_valid       = 1'b0;
        cmd_half_period = 16'd7;
        cmd_num_toggles = 8'd9;
        for (int s = 0; s <= total; s++) begin
            if (s > 0) step();
            chk("busy",  32'(busy),         32'(s < total));
            chk("done",  32'(done),         32'(s == total));
            chk("sig",   32'(sig_out),      32'((s / t) % 2));
            chk("left",  32'(toggles_left), 32'(n - s / t));
            chk("ready", 32'(cmd_ready),    32'd0);
        end
        step();
        chk("done_end",  32'(done),      32'd0);
        chk("ready_end", 32'(cmd_ready), 32'd1);
        chk("busy_end",  32'(busy),      32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_half_period = 16'd0;
        cmd_num_toggles = 8'd0;
        abort           = 1'b0;
        repeat (3) step();
        chk("rst_sig",     32'(sig_out),      32'd0);
        chk("rst_ready",   32'(cmd_ready),    32'd1);
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_done",    32'(done),         32'd0);
        chk("rst_aborted", 32'(aborted),      32'd0);
        chk("rst_left",    32'(toggles_left), 32'd0);
        reset = 1'b0;
        step();

        // abort in IDLE masks cmd_ready and blocks acceptance
        abort           = 1'b1;
        cmd_valid       = 1'b1;
        cmd_half_period = 16'd2;
        cmd_num_toggles = 8'd3;
        #1;
        chk("idle_abort_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("idle_abort_busy",    32'(busy),         32'd0);
        chk("idle_abort_aborted", 32'(aborted),      32'd0);
        chk("idle_abort_left",    32'(toggles_left), 32'd0);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        step();

        run_burst(3, 4);
        run_burst(0, 2);
        run_burst(0, 0);
        run_burst(7, 0);
        run_burst(2, 6);

        // H=5,N=10 with abort after the third toggle; cmd_valid held during burst
        cmd_valid       = 1'b1;
        cmd_half_period = 16'd5;
        cmd_num_toggles = 8'd10;
        step();
        cmd_half_period = 16'd1;
        cmd_num_toggles = 8'd1;
        repeat (15) step();
        chk("ab_sig",   32'(sig_out),      32'd1);
        chk("ab_left",  32'(toggles_left), 32'd7);
        chk("ab_busy",  32'(busy),         32'd1);
        chk("ab_ready", 32'(cmd_ready),    32'd0);
        abort = 1'b1;
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("ab_sig_after",  32'(sig_out),      32'd0);
        chk("ab_pulse",      32'(aborted),      32'd1);
        chk("ab_no_done",    32'(done),         32'd0);
        chk("ab_busy_after", 32'(busy),         32'd0);
        chk("ab_left_after", 32'(toggles_left), 32'd0);
        chk("ab_ready_after",32'(cmd_ready),    32'd1);
        step();
        chk("ab_pulse_end", 32'(aborted), 32'd0);
        chk("ab_done_end",  32'(done),    32'd0);

        // abort coinciding with the final period expiry: abort wins, no done
        cmd_valid       = 1'b1;
        cmd_half_period = 16'd1;
        cmd_num_toggles = 8'd1;
        step();
        cmd_valid = 1'b0;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("prio_aborted", 32'(aborted), 32'd1);
        chk("prio_done",    32'(done),    32'd0);
        chk("prio_sig",     32'(sig_out), 32'd0);
        step();
        chk("prio_done2",   32'(done),    32'd0);

        // reset mid-burst
        cmd_valid       = 1'b1;
        cmd_half_period = 16'd2;
        cmd_num_toggles = 8'd6;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        chk("mid_left_pre", 32'(toggles_left), 32'd4);
        reset = 1'b1;
        step();
        chk("mid_sig",     32'(sig_out),      32'd0);
        chk("mid_busy",    32'(busy),         32'd0);
        chk("mid_left",    32'(toggles_left), 32'd0);
        chk("mid_done",    32'(done),         32'd0);
        chk("mid_aborted", 32'(aborted),      32'd0);
        reset = 1'b0;
        step();
        run_burst(1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
